// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
//   Sequencing front end for the 8-bit combinational ALU. Accepts one command
//   at a time over a valid/ready handshake, reads operands from a private
//   4x8 register file, drives the ALU inputs, and commits the result and flags
//   to the register file and the 4-bit status register {C,S,V,Z}.
//   Shift commands (SHR/SHL) are repeated 1..8 times using single-bit ALU
//   shifts, so a command occupies the block for cnt+1 cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid_in      command present
//   cmd_ready_out     command can be accepted (high only while idle)
//   cmd_op_in         ALU opcode (0 SHR,1 SHL,4 INC,5 DEC,6 ADD,8 NOT,9 AND,
//                     a OR,b MOV; anything else is illegal)
//   cmd_dst_in        destination register index
//   cmd_src_in        source register index
//   cmd_imm_in        immediate operand
//   cmd_use_imm_in    source operand is the immediate instead of R[src]
//   cmd_cnt_in        shift iterations minus one (shift opcodes only)
//   alu_a_out/b_out   ALU operand inputs
//   alu_op_out        ALU opcode input
//   alu_status_out    ALU incoming status
//   alu_result_in     ALU result
//   alu_status_in     ALU outgoing status
//   status_out        committed status {C,S,V,Z}
//   done_out          one-cycle pulse on command completion
//   err_out           one-cycle pulse alongside done_out for an illegal opcode
//   dbg_sel_in        register-file read select
//   dbg_data_out      R[dbg_sel_in], combinational

module alu_exec_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic [3:0] cmd_op_in,
  input  logic [1:0] cmd_dst_in,
  input  logic [1:0] cmd_src_in,
  input  logic [7:0] cmd_imm_in,
  input  logic       cmd_use_imm_in,
  input  logic [2:0] cmd_cnt_in,
  output logic [7:0] alu_a_out,
  output logic [7:0] alu_b_out,
  output logic [3:0] alu_op_out,
  output logic [3:0] alu_status_out,
  input  logic [7:0] alu_result_in,
  input  logic [3:0] alu_status_in,
  output logic [3:0] status_out,
  output logic       done_out,
  output logic       err_out,
  input  logic [1:0] dbg_sel_in,
  output logic [7:0] dbg_data_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OP_SHR = 4'h0,
    OP_SHL = 4'h1,
    OP_INC = 4'h4,
    OP_DEC = 4'h5,
    OP_ADD = 4'h6,
    OP_NOT = 4'h8,
    OP_AND = 4'h9,
    OP_OR  = 4'ha,
    OP_MOV = 4'hb
  } op_e;

  state_e      state_q;
  logic [7:0]  rf_q [4];
  logic [3:0]  status_q;
  logic [7:0]  work_q;
  logic [7:0]  b_q;
  logic [3:0]  wstat_q;
  logic [2:0]  iter_q;
  logic [3:0]  op_q;
  logic [1:0]  dst_q;
  logic        legal_q;
  logic        done_q;
  logic        err_q;

  // Decode of the incoming command, used only at the handshake.
  logic [7:0]  src_d;
  logic        legal_d;
  logic        binary_d;
  logic        shift_d;

  always_comb begin
    src_d    = cmd_use_imm_in ? cmd_imm_in : rf_q[cmd_src_in];
    legal_d  = 1'b0;
    binary_d = 1'b0;
    shift_d  = 1'b0;
    case (cmd_op_in)
      OP_SHR, OP_SHL: begin
        legal_d = 1'b1;
        shift_d = 1'b1;
      end
      OP_INC, OP_DEC, OP_NOT, OP_MOV: begin
        legal_d = 1'b1;
      end
      OP_ADD, OP_AND, OP_OR: begin
        legal_d  = 1'b1;
        binary_d = 1'b1;
      end
      default: begin
        legal_d = 1'b0;
      end
    endcase
  end

  // While idle the ALU sees a harmless MOV of zero carrying the committed
  // status; during execution it sees the working operands.
  always_comb begin
    if (state_q == S_EXEC) begin
      alu_a_out      = work_q;
      alu_b_out      = b_q;
      alu_op_out     = op_q;
      alu_status_out = wstat_q;
    end else begin
      alu_a_out      = '0;
      alu_b_out      = '0;
      alu_op_out     = OP_MOV;
      alu_status_out = status_q;
    end
  end

  assign cmd_ready_out = (state_q == S_IDLE);
  assign status_out    = status_q;
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign dbg_data_out  = rf_q[dbg_sel_in];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rf_q     <= '{default: '0};
      status_q <= '0;
      work_q   <= '0;
      b_q      <= '0;
      wstat_q  <= '0;
      iter_q   <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      legal_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_in) begin
            op_q    <= cmd_op_in;
            dst_q   <= cmd_dst_in;
            legal_q <= legal_d;
            // Binary ops operate on R[dst] with SRC as the second operand;
            // unary ops operate directly on SRC.
            work_q  <= binary_d ? rf_q[cmd_dst_in] : src_d;
            b_q     <= src_d;
            wstat_q <= status_q;
            iter_q  <= shift_d ? cmd_cnt_in : '0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Intermediate shift results and flags stay local until the final
          // iteration, so only the last step's flags reach status_q.
          work_q  <= alu_result_in;
          wstat_q <= alu_status_in;
          if (!legal_q) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (iter_q != '0) begin
            iter_q <= iter_q - 3'd1;
          end else begin
            rf_q[dst_q] <= alu_result_in;
            status_q    <= alu_status_in;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid_in = 1'b0;
  logic       cmd_ready_out;
  logic [3:0] cmd_op_in = '0;
  logic [1:0] cmd_dst_in = '0;
  logic [1:0] cmd_src_in = '0;
  logic [7:0] cmd_imm_in = '0;
  logic       cmd_use_imm_in = 1'b0;
  logic [2:0] cmd_cnt_in = '0;
  logic [7:0] alu_a_out, alu_b_out;
  logic [3:0] alu_op_out, alu_status_out;
  logic [7:0] alu_result_in;
  logic [3:0] alu_status_in;
  logic [3:0] status_out;
  logic       done_out, err_out;
  logic [1:0] dbg_sel_in = '0;
  logic [7:0] dbg_data_out;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_in   (cmd_valid_in),
    .cmd_ready_out  (cmd_ready_out),
    .cmd_op_in      (cmd_op_in),
    .cmd_dst_in     (cmd_dst_in),
    .cmd_src_in     (cmd_src_in),
    .cmd_imm_in     (cmd_imm_in),
    .cmd_use_imm_in (cmd_use_imm_in),
    .cmd_cnt_in     (cmd_cnt_in),
    .alu_a_out      (alu_a_out),
    .alu_b_out      (alu_b_out),
    .alu_op_out     (alu_op_out),
    .alu_status_out (alu_status_out),
    .alu_result_in  (alu_result_in),
    .alu_status_in  (alu_status_in),
    .status_out     (status_out),
    .done_out       (done_out),
    .err_out        (err_out),
    .dbg_sel_in     (dbg_sel_in),
    .dbg_data_out   (dbg_data_out)
  );

  // Behavioural model of the combinational ALU; status is {C,S,V,Z}.
  always_comb begin
    logic [8:0] sum;
    logic       c, v;
    logic [7:0] r;
    sum = '0;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (alu_op_out)
      4'h0: begin r = alu_a_out >> 1; c = alu_a_out[0]; end
      4'h1: begin r = alu_a_out << 1; c = alu_a_out[7]; end
      4'h4: begin sum = {1'b0, alu_a_out} + 9'd1; r = sum[7:0]; c = sum[8]; v = (alu_a_out == 8'h7F); end
      4'h5: begin sum = {1'b0, alu_a_out} + 9'h0FF; r = sum[7:0]; c = sum[8]; v = (alu_a_out == 8'h80); end
      4'h6: begin
        sum = {1'b0, alu_a_out} + {1'b0, alu_b_out};
        r = sum[7:0];
        c = sum[8];
        v = (alu_a_out[7] == alu_b_out[7]) && (r[7] != alu_a_out[7]);
      end
      4'h8: r = ~alu_a_out;
      4'h9: r = alu_a_out & alu_b_out;
      4'ha: r = alu_a_out | alu_b_out;
      4'hb: r = alu_a_out;
      default: r = '0;
    endcase
    alu_result_in = r;
    if (alu_op_out inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'ha, 4'hb})
      alu_status_in = {c, r[7], v, (r == 8'h00)};
    else
      alu_status_in = alu_status_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] imm;
    logic       use_imm;
    logic [2:0] cnt;
    logic [7:0] exp_val;
    logic [3:0] exp_st;
    int         exp_n;
    logic       exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic run_cmd(input string tag, input vec_t v);
    int  waitc = 0;
    int  k = 0;
    int  busy = 0;
    bit  seen = 0;
    @(negedge clk);
    while (!cmd_ready_out && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk($sformatf("%s ready_before", tag), cmd_ready_out, 1);
    cmd_op_in      = v.op;
    cmd_dst_in     = v.dst;
    cmd_src_in     = v.src;
    cmd_imm_in     = v.imm;
    cmd_use_imm_in = v.use_imm;
    cmd_cnt_in     = v.cnt;
    dbg_sel_in     = v.dst;
    cmd_valid_in   = 1'b1;
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (done_out) seen = 1;
      else if (!cmd_ready_out) busy++;
    end
    chk($sformatf("%s done_seen", tag), seen, 1);
    chk($sformatf("%s done_latency", tag), k, v.exp_n + 1);
    chk($sformatf("%s busy_cycles", tag), busy, v.exp_n);
    chk($sformatf("%s err", tag), err_out, v.exp_err);
    chk($sformatf("%s ready_in_done", tag), cmd_ready_out, 1);
    chk($sformatf("%s dst_val", tag), dbg_data_out, v.exp_val);
    chk($sformatf("%s status", tag), status_out, v.exp_st);
    @(negedge clk);
    chk($sformatf("%s done_single", tag), done_out, 0);
  endtask

  initial begin
    //         op    dst   src   imm    imm? cnt   val    st     N  err
    vecs[0]  = '{4'hb, 2'd0, 2'd0, 8'h7F, 1'b1, 3'd0, 8'h7F, 4'h0, 1, 1'b0};
    vecs[1]  = '{4'h6, 2'd0, 2'd0, 8'h01, 1'b1, 3'd0, 8'h80, 4'h6, 1, 1'b0};
    vecs[2]  = '{4'hb, 2'd1, 2'd0, 8'h81, 1'b1, 3'd0, 8'h81, 4'h4, 1, 1'b0};
    vecs[3]  = '{4'h1, 2'd1, 2'd1, 8'h00, 1'b0, 3'd2, 8'h08, 4'h0, 3, 1'b0};
    vecs[4]  = '{4'hb, 2'd2, 2'd0, 8'h00, 1'b1, 3'd0, 8'h00, 4'h1, 1, 1'b0};
    vecs[5]  = '{4'h5, 2'd2, 2'd2, 8'h00, 1'b0, 3'd0, 8'hFF, 4'h4, 1, 1'b0};
    vecs[6]  = '{4'h4, 2'd2, 2'd2, 8'h00, 1'b0, 3'd0, 8'h00, 4'h9, 1, 1'b0};
    vecs[7]  = '{4'h9, 2'd0, 2'd0, 8'hF0, 1'b1, 3'd0, 8'h80, 4'h4, 1, 1'b0};
    vecs[8]  = '{4'ha, 2'd1, 2'd0, 8'h00, 1'b0, 3'd0, 8'h88, 4'h4, 1, 1'b0};
    vecs[9]  = '{4'h8, 2'd3, 2'd1, 8'h00, 1'b0, 3'd0, 8'h77, 4'h0, 1, 1'b0};
    vecs[10] = '{4'h0, 2'd3, 2'd0, 8'h81, 1'b1, 3'd0, 8'h40, 4'h8, 1, 1'b0};
    vecs[11] = '{4'h6, 2'd3, 2'd0, 8'hC0, 1'b1, 3'd0, 8'h00, 4'h9, 1, 1'b0};
    vecs[12] = '{4'h1, 2'd3, 2'd0, 8'h01, 1'b1, 3'd7, 8'h00, 4'h9, 8, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", cmd_ready_out, 1);
    chk("rst done", done_out, 0);
    chk("rst err", err_out, 0);
    chk("rst status", status_out, 4'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel_in = 2'(i);
      #1 chk($sformatf("rst R%0d", i), dbg_data_out, 8'h00);
    end

    for (int i = 0; i < 13; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Illegal opcode with valid held, then a second command presented while busy
    @(negedge clk);
    dbg_sel_in     = 2'd0;
    cmd_op_in      = 4'h3;
    cmd_dst_in     = 2'd0;
    cmd_imm_in     = 8'hAA;
    cmd_use_imm_in = 1'b1;
    cmd_cnt_in     = 3'd5;
    cmd_valid_in   = 1'b1;
    @(posedge clk);
    #1;
    cmd_op_in  = 4'hb;
    cmd_imm_in = 8'h55;
    cmd_cnt_in = 3'd0;
    @(negedge clk);
    chk("ill busy_ready", cmd_ready_out, 0);
    chk("ill busy_done", done_out, 0);
    @(negedge clk);
    chk("ill done", done_out, 1);
    chk("ill err", err_out, 1);
    chk("ill ready", cmd_ready_out, 1);
    chk("ill status_kept", status_out, 4'h9);
    chk("ill R0_kept", dbg_data_out, 8'h80);
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    @(negedge clk);
    chk("ill2 busy_ready", cmd_ready_out, 0);
    chk("ill2 busy_done", done_out, 0);
    chk("ill2 R0_pending", dbg_data_out, 8'h80);
    @(negedge clk);
    chk("ill2 done", done_out, 1);
    chk("ill2 err", err_out, 0);
    chk("ill2 R0", dbg_data_out, 8'h55);
    chk("ill2 status", status_out, 4'h0);

    // Long shift abandoned by reset in its 4th EXEC cycle
    run_cmd("rstseq_mov", '{4'hb, 2'd3, 2'd0, 8'hFF, 1'b1, 3'd0, 8'hFF, 4'h4, 1, 1'b0});
    cmd_op_in      = 4'h0;
    cmd_dst_in     = 2'd3;
    cmd_src_in     = 2'd3;
    cmd_use_imm_in = 1'b0;
    cmd_cnt_in     = 3'd7;
    dbg_sel_in     = 2'd3;
    cmd_valid_in   = 1'b1;
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstseq busy", cmd_ready_out, 0);
    rst_n = 1'b0;
    #1;
    chk("rstseq async_ready", cmd_ready_out, 1);
    chk("rstseq async_R3", dbg_data_out, 8'h00);
    chk("rstseq async_status", status_out, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dones = 0;
      int notready = 0;
      repeat (12) begin
        @(negedge clk);
        if (done_out || err_out) dones++;
        if (!cmd_ready_out) notready++;
      end
      chk("rstseq no_done", dones, 0);
      chk("rstseq ready_after", notready, 0);
    end
    chk("rstseq status", status_out, 4'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel_in = 2'(i);
      #1 chk($sformatf("rstseq R%0d", i), dbg_data_out, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
